// File: rtl/zoom_pkg.sv
// rtl/zoom_pkg.sv - shared constants and types for the zoom engine and controller
//
// Contents:
//   ALG_*          algorithm codes driven on algorithm_select
//   ZOOM_*         zoom-level constants shared with the zoom controller
//   zoom_state_e   engine state encoding
//   pix_class_e    per-output-pixel processing class
package zoom_pkg;

    localparam logic [1:0] ALG_NN  = 2'b00;  // nearest-neighbour zoom in
    localparam logic [1:0] ALG_REP = 2'b01;  // pixel-replication zoom in
    localparam logic [1:0] ALG_DEC = 2'b10;  // decimation zoom out
    localparam logic [1:0] ALG_AVG = 2'b11;  // 2x2 block-average zoom out

    // Each engine request is one 2x step; the controller tracks the level.
    localparam int ZOOM_STEP    = 2;
    localparam int ZOOM_LVL_W   = 3;
    localparam int ZOOM_LVL_MIN = -2;
    localparam int ZOOM_LVL_MAX = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PIXEL = 2'd1,
        ST_DONE  = 2'd2
    } zoom_state_e;

    // COPY: 1 read + write, AVG: 4 reads + write, BORDER: write of 0 only.
    typedef enum logic [1:0] {
        CLS_COPY   = 2'd0,
        CLS_AVG    = 2'd1,
        CLS_BORDER = 2'd2
    } pix_class_e;

endpackage

// File: rtl/zoom_engine_addr_gen.sv
// rtl/zoom_engine_addr_gen.sv - maps output pixel and read phase to source address and class
//
// Ports:
//   x, y       output pixel coordinates
//   alg        latched algorithm code
//   rd_idx     read index within a 2x2 block (bit0 = +x, bit1 = +y)
//   src_addr   source address for this read, y*IMG_W + x
//   pix_class  how the output pixel is produced
module zoom_addr_gen
    import zoom_pkg::*;
#(
    parameter int IMG_W  = 160,
    parameter int IMG_H  = 120,
    parameter int ADDR_W = 15,
    parameter int XW     = $clog2(IMG_W),
    parameter int YW     = $clog2(IMG_H)
) (
    input  logic [XW-1:0]     x,
    input  logic [YW-1:0]     y,
    input  logic [1:0]        alg,
    input  logic [1:0]        rd_idx,
    output logic [ADDR_W-1:0] src_addr,
    output pix_class_e        pix_class
);

    localparam logic [ADDR_W-1:0] W_A = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] CX  = ADDR_W'(IMG_W / 4);
    localparam logic [ADDR_W-1:0] CY  = ADDR_W'(IMG_H / 4);
    localparam logic [XW-1:0]     X_LO = XW'(IMG_W / 4);
    localparam logic [XW-1:0]     X_HI = XW'(3 * IMG_W / 4);
    localparam logic [YW-1:0]     Y_LO = YW'(IMG_H / 4);
    localparam logic [YW-1:0]     Y_HI = YW'(3 * IMG_H / 4);

    logic [ADDR_W-1:0] xa, ya, sx, sy;
    logic              inner;

    assign xa    = ADDR_W'(x);
    assign ya    = ADDR_W'(y);
    assign inner = (x >= X_LO) && (x < X_HI) && (y >= Y_LO) && (y < Y_HI);

    always_comb begin
        sx        = '0;
        sy        = '0;
        pix_class = CLS_COPY;
        if (!alg[1]) begin
            // Zoom in: centre crop, each source pixel covers a 2x2 output block.
            sx = (xa >> 1) + CX;
            sy = (ya >> 1) + CY;
        end else if (inner) begin
            sx = ((xa - CX) << 1) + ADDR_W'(rd_idx[0]);
            sy = ((ya - CY) << 1) + ADDR_W'(rd_idx[1]);
            pix_class = (alg == ALG_AVG) ? CLS_AVG : CLS_COPY;
        end else begin
            pix_class = CLS_BORDER;
        end
        src_addr = sy * W_A + sx;
    end

endmodule

// File: rtl/zoom_engine.sv
// rtl/zoom_engine.sv - 2x zoom datapath sweeping one output frame per enable request
//
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   enable              start/hold request; dropping it mid-sweep aborts
//   algorithm_select    algorithm code, latched at start
//   done, busy          frame complete / sweep in progress
//   src_addr, src_data  source RAM read port (data one cycle after address)
//   dst_addr, dst_data, dst_we  destination RAM write port
// Build option: ROUND_AVG_EN rounds the block average instead of truncating.
module zoom_engine
    import zoom_pkg::*;
#(
    parameter int IMG_W  = 160,
    parameter int IMG_H  = 120,
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [1:0]        algorithm_select,
    output logic              done,
    output logic              busy,
    output logic [ADDR_W-1:0] src_addr,
    input  logic [PIX_W-1:0]  src_data,
    output logic [ADDR_W-1:0] dst_addr,
    output logic [PIX_W-1:0]  dst_data,
    output logic              dst_we
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam logic [XW-1:0]     X_MAX = XW'(IMG_W - 1);
    localparam logic [YW-1:0]     Y_MAX = YW'(IMG_H - 1);
    localparam logic [ADDR_W-1:0] W_A   = ADDR_W'(IMG_W);

    zoom_state_e       state_q, state_d;
    logic [XW-1:0]     x_q;
    logic [YW-1:0]     y_q;
    logic [2:0]        phase_q;
    logic [PIX_W+1:0]  acc_q;
    logic [1:0]        alg_q;

    pix_class_e        cls;
    logic [ADDR_W-1:0] rd_addr;
    logic [2:0]        wr_phase;
    logic              in_pixel, is_wr, last_pix;
    logic [PIX_W+1:0]  sum, sum_r;
    logic [PIX_W-1:0]  avg;

    zoom_addr_gen #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .ADDR_W(ADDR_W),
        .XW    (XW),
        .YW    (YW)
    ) u_addr_gen (
        .x        (x_q),
        .y        (y_q),
        .alg      (alg_q),
        .rd_idx   (phase_q[1:0]),
        .src_addr (rd_addr),
        .pix_class(cls)
    );

    // The fourth sample arrives during the write cycle, so the final sum
    // is formed combinationally from the accumulator plus src_data.
    assign sum = acc_q + {2'b00, src_data};
`ifdef ROUND_AVG_EN
    assign sum_r = sum + (PIX_W+2)'(2);
`else
    assign sum_r = sum;
`endif
    assign avg = sum_r[PIX_W+1:2];

    always_comb begin
        wr_phase = 3'd0;
        case (cls)
            CLS_COPY:   wr_phase = 3'd1;
            CLS_AVG:    wr_phase = 3'd4;
            default:    wr_phase = 3'd0;
        endcase
        in_pixel = (state_q == ST_PIXEL);
        is_wr    = in_pixel && (phase_q == wr_phase);
        last_pix = (x_q == X_MAX) && (y_q == Y_MAX);
    end

    always_comb begin
        state_d  = state_q;
        done     = (state_q == ST_DONE);
        busy     = in_pixel;
        // A dropped enable suppresses the write in the aborting cycle too.
        dst_we   = is_wr && enable;
        src_addr = (in_pixel && !is_wr) ? rd_addr : '0;
        dst_addr = in_pixel ? (ADDR_W'(y_q) * W_A + ADDR_W'(x_q)) : '0;
        dst_data = '0;
        if (dst_we) begin
            case (cls)
                CLS_COPY: dst_data = src_data;
                CLS_AVG:  dst_data = avg;
                default:  dst_data = '0;
            endcase
        end
        case (state_q)
            ST_IDLE:  if (enable) state_d = ST_PIXEL;
            ST_PIXEL: begin
                if (!enable)
                    state_d = ST_IDLE;
                else if (is_wr && last_pix)
                    state_d = ST_DONE;
            end
            ST_DONE:  if (!enable) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            phase_q <= '0;
            acc_q   <= '0;
            alg_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && enable) begin
                alg_q   <= algorithm_select;
                x_q     <= '0;
                y_q     <= '0;
                phase_q <= '0;
                acc_q   <= '0;
            end else if (in_pixel && enable) begin
                // Phase 0 is always the first read (or the border write),
                // so the accumulator restarts there for every pixel.
                acc_q <= (phase_q == 3'd0) ? '0 : sum;
                if (is_wr) begin
                    phase_q <= '0;
                    if (x_q == X_MAX) begin
                        x_q <= '0;
                        y_q <= y_q + 1'b1;
                    end else begin
                        x_q <= x_q + 1'b1;
                    end
                end else begin
                    phase_q <= phase_q + 3'd1;
                end
            end
        end
    end

endmodule

// File: doc/zoom_engine.md
Name: zoom_engine

Overview:
- Datapath responder to the zoom controller's enable/done handshake.
- On enable it sweeps one full output frame, reading the current image from a source buffer and writing the zoomed result to a destination buffer, then raises done.
- It performs one 2x step per request. Algorithm codes: 00 nearest-neighbour in, 01 pixel-replication in, 10 decimation out, 11 block-average out.
- The controller's wren, one cycle after done, commits or swaps the buffers; that logic is outside this block.

Parameters:
- IMG_W, 160, frame width in pixels; must be even and divisible by 4.
- IMG_H, 120, frame height in pixels; must be even and divisible by 4.
- PIX_W, 8, grayscale pixel width.
- ADDR_W, 15, buffer address width; must be at least clog2(IMG_W*IMG_H).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- enable  in  1  start/hold request from the controller.
- algorithm_select  in  2  algorithm code.
- done  out  1  frame complete.
- busy  out  1  sweep in progress.
- src_addr  out  ADDR_W  source read address; src_addr = y*IMG_W + x.
- src_data  in  PIX_W  source pixel, valid the cycle after src_addr (synchronous RAM).
- dst_addr  out  ADDR_W  destination write address.
- dst_data  out  PIX_W  destination write data.
- dst_we  out  1  destination write strobe.

Behaviour:
- Reset: state IDLE; done, busy, dst_we = 0; src_addr, dst_addr, dst_data = 0; counters = 0.
- States:
  - IDLE: if enable=1, latch algorithm_select, clear x/y to 0, set busy, go to PIXEL. Otherwise stay in IDLE.
  - PIXEL: process output pixel (x,y) according to its class (below), then advance raster order: x+1, wrapping to 0 at IMG_W-1 with y+1.
  - PIXEL to DONE: after the write of pixel (IMG_W-1, IMG_H-1).
  - DONE: done=1, busy=0. Hold until enable=0, then go to IDLE with done=0 the next cycle.
- Zoom-in (00/01), every pixel is a copy pixel:
  - source pixel = (x>>1 + IMG_W/4, y>>1 + IMG_H/4), a centre crop.
  - 00 and 01 are identical at integer 2x.
- Zoom-out (10/11):
  - inner region: IMG_W/4 <= x < 3*IMG_W/4 and IMG_H/4 <= y < 3*IMG_H/4.
  - in that region, with x' = x - IMG_W/4 and y' = y - IMG_H/4:
    - 10 is a copy pixel from source (2x', 2y').
    - 11 averages the 2x2 block at (2x', 2y').
  - pixels outside the inner region are border pixels, written as 0.
- Per-pixel timing:
  - copy pixel, 2 cycles: RD drives src_addr; WR drives dst_we=1 with dst_data=src_data.
  - average pixel, 5 cycles: RD0..RD3 drive the four addresses in order (x,y), (x+1,y), (x,y+1), (x+1,y+1). The PIX_W+2 bit accumulator adds src_data in RD1, RD2, RD3 and WR. WR writes sum>>2.
  - border pixel, 1 cycle: WR with dst_data=0, no source read.
- dst_we is high for exactly one cycle per output pixel; dst_addr = y*IMG_W + x.
- enable dropping to 0 while in PIXEL: abort to IDLE the next cycle with dst_we=0 and busy=0; the destination keeps whatever was already written; done is not asserted.
- enable staying at 1 while in DONE: no restart; done stays high.
- algorithm_select changes after the start are ignored.

Optional Feature:
- ROUND_AVG_EN defined: the average is rounded, (sum+2)>>2.
- ROUND_AVG_EN undefined: the average is truncated, sum>>2.
- Only algorithm 11 is affected.

Decomposition:
- Shared package zoom_pkg holds:
  - algorithm codes ALG_NN=2'b00, ALG_REP=2'b01, ALG_DEC=2'b10, ALG_AVG=2'b11.
  - zoom-level constants shared with the controller.
  - engine state encoding.
- One natural sub-module, zoom_addr_gen: combinational mapping from (x, y, algorithm, phase) to source address and pixel class. The top holds the FSM, counters and accumulator.

Test Plan:
All scenarios use IMG_W=8, IMG_H=4, src[a]=a, and the bench keeps enable=1 until done.
- Reset: reset=0 mid-sweep -> done=0, busy=0, dst_we=0 immediately; state IDLE after release.
- Algorithm 00 -> dst[0]=10, dst[1]=10, dst[2]=11, dst[31]=21; 32 writes; done rises 64 cycles after start.
- Algorithm 10 -> dst(2,1)=0, dst(3,1)=2, dst(2,2)=16, dst(0,0)=0; border writes 0; 32 writes; 40 cycles.
- Algorithm 11 -> dst(3,1)=6 without ROUND_AVG_EN and 7 with it (block 2+3+10+11=26); 64 cycles.
- enable dropped after 10 cycles of algorithm 00 -> IDLE next cycle, no done, no further dst_we; a new enable restarts at dst_addr=0.
- enable held in DONE for 20 cycles -> done stays 1, no writes; enable=0 -> done=0 the next cycle.
